// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Show-ahead receive FIFO; an extra pointer bit separates full
//               from empty.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign wr_en = push && (!full || rd_en);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_core
// Description : 8N1 UART receiver with input synchroniser, FIFO buffering and
//               framing/overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FREQ       = 10_000_000,
    parameter int BAUD       = 100_000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(UART_DATA_BITS);

    uart_rx_state_e            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [BW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      rx_meta_q, rx_s_q;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      half_done, bit_done, last_bit;
    logic                      push, pop, fifo_empty, fifo_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign half_done = (cnt_q == CW'(HALF_BIT - 1));
    assign bit_done  = (cnt_q == CW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_idx_q == BW'(UART_DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!rx_s_q) state_d = START;
            START:   if (half_done) state_d = rx_s_q ? IDLE : DATA;
            DATA:    if (bit_done && last_bit) state_d = STOP;
            STOP:    if (bit_done) state_d = rx_s_q ? IDLE : BREAK;
            BREAK:   if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        push        = (state_q == STOP) && bit_done && rx_s_q;
        frame_err_d = (state_q == STOP) && bit_done && !rx_s_q;
        overrun_d   = push && fifo_full && !pop;
    end

    always_comb begin
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            START: cnt_d = half_done ? '0 : cnt_q + 1'b1;
            DATA: begin
                if (bit_done) begin
                    cnt_d     = '0;
                    // LSB arrives first, so it ends up at bit 0 after 8 shifts.
                    shift_d   = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP:    cnt_d = bit_done ? '0 : cnt_q + 1'b1;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign valid_o     = !fifo_empty;
    assign pop         = valid_o && ready_i;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (data_o),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_core
// Description : Self-checking bench for uart_rx_core with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int CPB   = 100;
    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_hi = 0;

    uart_rx_core #(
        .FREQ       (10_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Observer: records accepted bytes and pulse counts mid-cycle.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1) begin
            if (valid_o === 1'b1) valid_hi++;
            if (valid_o === 1'b1 && ready_i === 1'b1) rx_q.push_back(data_o);
            if (frame_err_o === 1'b1) fe_cnt++;
            if (overrun_o === 1'b1) ov_cnt++;
            if (frame_err_o === 1'b1 && overrun_o === 1'b1) both_cnt++;
        end
    end

    task automatic clear_mon();
        rx_q.delete();
        fe_cnt = 0; ov_cnt = 0; both_cnt = 0; valid_hi = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err_o); end
        n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_single();
        int lat = 0;
        bit got = 1'b0;
        ready_i = 1'b1;
        clear_mon();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= 2000 && !got; i++) begin
                    @(negedge clk); #1;
                    if (valid_o === 1'b1) begin got = 1'b1; lat = i; end
                end
            end
        join
        repeat (20) @(negedge clk);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL single_timeout: valid seen %b expected 1", got); end
        n_checks++; if (lat != 953) begin n_fail++; $display("FAIL single_latency: got %0d expected 953", lat); end
        n_checks++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
        else begin
            n_checks++; if (rx_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", rx_q[0]); end
        end
        n_checks++; if (valid_hi != 1) begin n_fail++; $display("FAIL single_valid_width: got %0d expected 1", valid_hi); end
        n_checks++; if (fe_cnt != 0 || ov_cnt != 0) begin n_fail++; $display("FAIL single_pulses: got fe=%0d ov=%0d expected 0/0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        ready_i = 1'b0;
        clear_mon();
        for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1);
        rx_i = 1'b1;
        repeat (60) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== exp_b[k]) begin
                n_fail++; $display("FAIL b2b_pop%0d: got valid=%b data=%h expected 1/%h", k, valid_o, data_o, exp_b[k]);
            end
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0;
        end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", valid_o); end
    endtask

    task automatic test_overrun();
        logic [7:0] b [5];
        logic [7:0] model_q[$];
        int model_ov = 0;
        ready_i = 1'b0;
        clear_mon();
        for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
        for (int k = 0; k < 5; k++) begin
            if (model_q.size() < DEPTH) model_q.push_back(b[k]);
            else model_ov++;
        end
        for (int k = 0; k < 4; k++) send_frame(b[k], 1'b1);
        n_checks++; if (ov_cnt != 0) begin n_fail++; $display("FAIL ovr_early: got %0d expected 0", ov_cnt); end
        send_frame(b[4], 1'b1);
        rx_i = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (ov_cnt != model_ov) begin n_fail++; $display("FAIL ovr_count: got %0d expected %0d", ov_cnt, model_ov); end
        n_checks++; if (fe_cnt != 0) begin n_fail++; $display("FAIL ovr_fe: got %0d expected 0", fe_cnt); end
        while (model_q.size() > 0) begin
            logic [7:0] e;
            e = model_q.pop_front();
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== e) begin
                n_fail++; $display("FAIL ovr_drain: got valid=%b data=%h expected 1/%h", valid_o, data_o, e);
            end
            ready_i = 1'b1; @(negedge clk); ready_i = 1'b0;
        end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b expected 0", valid_o); end
    endtask

    task automatic test_break();
        ready_i = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        n_checks++; if (fe_cnt != 1) begin n_fail++; $display("FAIL brk_fe: got %0d expected 1", fe_cnt); end
        n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL brk_push: got %0d bytes expected 0", rx_q.size()); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL brk_busy: got %b expected 1", busy_o); end
        rx_i = 1'b1;
        repeat (CPB) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL brk_idle: got %b expected 0", busy_o); end
        send_frame(8'h12, 1'b1);
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h12) begin
            n_fail++; $display("FAIL brk_recover: got %0d bytes first=%h expected 1/12", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        n_checks++; if (fe_cnt != 1) begin n_fail++; $display("FAIL brk_fe_total: got %0d expected 1", fe_cnt); end
    endtask

    task automatic test_glitch();
        ready_i = 1'b1;
        clear_mon();
        rx_i = 1'b0;
        repeat (20) @(negedge clk);
        rx_i = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy: got %b expected 1", busy_o); end
        repeat (40) @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", busy_o); end
        repeat (100) @(negedge clk);
        n_checks++;
        if (fe_cnt != 0 || ov_cnt != 0 || valid_hi != 0) begin
            n_fail++; $display("FAIL glitch_quiet: got fe=%0d ov=%0d valid=%0d expected 0/0/0", fe_cnt, ov_cnt, valid_hi);
        end
    endtask

    task automatic test_reset_mid();
        ready_i = 1'b1;
        clear_mon();
        fork
            send_frame(8'h81, 1'b1);
            begin
                repeat (3 * CPB) @(negedge clk);
                n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_busy: got %b expected 1", busy_o); end
                rst_n = 1'b0;
                #1;
                n_checks++;
                if ({data_o, valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
                    n_fail++; $display("FAIL rstmid_outputs: got data=%h v=%b fe=%b ov=%b busy=%b expected all 0",
                                       data_o, valid_o, frame_err_o, overrun_o, busy_o);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        rx_i = 1'b1;
        repeat (15 * CPB) @(negedge clk);
        clear_mon();
        send_frame(8'h7E, 1'b1);
        repeat (60) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin
            n_fail++; $display("FAIL rstmid_recover: got %0d bytes first=%h expected 1/7e", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe = 0;
        bit done = 1'b0;
        clear_mon();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [7:0] b;
                    logic       stop_ok;
                    b       = 8'($urandom);
                    stop_ok = ($urandom_range(0, 3) != 0);
                    send_frame(b, stop_ok);
                    if (stop_ok) exp_q.push_back(b);
                    else exp_fe++;
                    rx_i = 1'b1;
                    repeat ($urandom_range(0, 2 * CPB) + (stop_ok ? 0 : CPB)) @(negedge clk);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_i = 1'b1;
        repeat (60) @(negedge clk);
        n_checks++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
            n_checks++; if (rx_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_data%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
        end
        n_checks++; if (fe_cnt != exp_fe) begin n_fail++; $display("FAIL rand_fe: got %0d expected %0d", fe_cnt, exp_fe); end
        n_checks++; if (ov_cnt != 0) begin n_fail++; $display("FAIL rand_ov: got %0d expected 0", ov_cnt); end
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL rand_coincident: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_break();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receive front end inside the SoC top. Consumes the serial `uart_rx` pin that the host-side UART model drives.
- Converts 8N1 frames into bytes and buffers them in a small FIFO.
- Presents bytes to the peripheral bus slave through a valid/ready interface.
- Reports framing errors and overruns as single-cycle pulses for the status/IRQ logic.

Parameters:
- FREQ, 10000000, core clock frequency in Hz
- BAUD, 100000, line rate in bit/s
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2
- CLKS_PER_BIT (localparam), FREQ/BAUD = 100, clocks per bit; must be at least 8
- HALF_BIT (localparam), CLKS_PER_BIT/2 = 50, start-bit mid-sample offset

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- rx_i  in  1  serial input, asynchronous to clk, idle high
- data_o  out  8  byte at the FIFO head
- valid_o  out  1  FIFO non-empty
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low
- overrun_o  out  1  one-cycle pulse: completed byte dropped because FIFO full
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, synchroniser flops=1, FSM=IDLE, FIFO empty, counters=0.
- Synchroniser: 2-flop chain produces rx_s, which lags rx_i by 2 clk cycles. All decisions use rx_s only.
- FSM states:
  - IDLE: when rx_s==0, go to START and clear the bit counter.
  - START:
    - Count to HALF_BIT-1, then sample rx_s.
    - Sample 0: go to DATA with cnt=0 and bit index=0.
    - Sample 1: treat as a glitch and return to IDLE with no pulse.
  - DATA:
    - Sample rx_s when cnt==CLKS_PER_BIT-1, then clear cnt.
    - Shift the sample into the MSB of the shift register; bytes are received LSB first.
    - After the 8th sample, go to STOP.
  - STOP, sampled at CLKS_PER_BIT-1:
    - Sample 1: push the byte and go straight to IDLE. Next-frame detection can begin in the second half of the stop bit, so back-to-back frames are supported.
    - Sample 0: pulse frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err_o pulse.
- Push timing: the push is registered, so valid_o rises the cycle after the stop sample.
- Total latency from an rx_i falling edge to valid_o: 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clk cycles, which is 953 at the defaults.
- FIFO is show-ahead: data_o is the head entry, valid_o = !empty, pop = valid_o && ready_i.
- Push while full:
  - With no pop in the same cycle: the byte is dropped, overrun_o pulses, FIFO contents are unchanged.
  - With a pop in the same cycle: the push is accepted and no overrun occurs.
- Push and pop in the same cycle while empty: the push lands and valid_o rises the next cycle; no bypass.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- frame_err_o and overrun_o are registered and high for exactly one cycle. They can never assert in the same cycle.
- Reset asserted mid-frame: all state returns to reset values asynchronously and FIFO contents are lost. After release the FSM waits for rx_s==0 from IDLE. A partial frame then re-syncs on the next falling edge, which may itself cause a framing error; this is acceptable.

Decomposition:
- Shared package uart_pkg contains:
  - uart_rx_state_e enum {IDLE, START, DATA, STOP, BREAK}.
  - Function clks_per_bit(freq, baud).
  - Constant UART_DATA_BITS = 8.
- Sub-module uart_rx_fifo holds the FIFO storage and pointers, with ports (WIDTH, DEPTH; clk, rst_n, push, wdata, pop, rdata, empty, full). The core holds only the synchroniser, FSM, counters and pulse generation.

Test Plan:
- Single byte 0xA5 at defaults, ready_i=1: valid_o is high for one cycle with data_o=0xA5. It rises 953 cycles after the start edge. frame_err_o and overrun_o stay 0.
- Back-to-back frames 0x00, 0xFF, 0x3C (stop bit exactly one bit long), ready_i=0: afterwards valid_o=1. Popping three times returns 0x00, 0xFF, 0x3C in order, then valid_o=0.
- Five frames with ready_i=0 and FIFO_DEPTH=4: the first four bytes are kept. overrun_o pulses once, after the fifth frame's stop sample. Draining yields only the first four bytes.
- Frame 0x55 with stop bit forced 0, line then held low for 3 bit times: frame_err_o pulses exactly once, no push occurs, and the FSM stays in BREAK. After the line returns high, 0x12 is received correctly.
- Start glitch: rx_i low for 20 cycles, then high: busy_o rises then falls at the START sample, and there are no pulses and no push.
- rst_n asserted during the DATA bits of 0x81, released 1 cycle later: all outputs are 0 immediately. A following clean 0x7E frame is received with data_o=0x7E.
